// File: rtl/rr_arbiter_ctrl.sv
// Four-requester round-robin arbiter behind the 8-bit io_in/io_out user-module pinout.
// Define ARB_TIMEOUT_EN to bound each grant to TIMEOUT cycles and raise the sticky tmo flag.
module rr_arbiter_ctrl #(
    parameter int TIMEOUT = 8
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;

    assign clk   = io_in[0];
    assign rst_n = io_in[1];
    assign req   = io_in[5:2];
    assign done  = io_in[6];

    state_t     state;
    state_t     state_nxt;
    logic [3:0] gnt;
    logic [3:0] gnt_nxt;
    logic [1:0] gnt_idx;
    logic [1:0] idx_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [1:0] winner;
    logic       normal_exit;
    logic       limit_hit;
    logic       busy;
    logic       tmo;

    // Scan from farthest to nearest so the requester closest to ptr wins.
    always_comb begin
        winner = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                winner = ptr + 2'(k);
            end
        end
    end

    assign normal_exit = done | ~req[gnt_idx];

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        idx_nxt   = gnt_idx;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 4'b0001 << winner;
                    idx_nxt   = winner;
                end else begin
                    gnt_nxt = 4'b0000;
                end
            end
            GRANT: begin
                if (normal_exit || limit_hit) begin
                    state_nxt = RELEASE;
                    gnt_nxt   = 4'b0000;
                    ptr_nxt   = gnt_idx + 2'd1;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            gnt_idx <= 2'd0;
            ptr     <= 2'd0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= idx_nxt;
            ptr     <= ptr_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [3:0] HOLD_LIMIT = 4'(TIMEOUT - 1);

    logic [3:0] hold_cnt;
    logic       grant_entry;
    logic       timeout_exit;
    logic       unused_sink;

    assign grant_entry  = (state == IDLE) && (|req);
    assign limit_hit    = (state == GRANT) && (hold_cnt == HOLD_LIMIT);
    assign timeout_exit = limit_hit && !normal_exit;
    assign unused_sink  = io_in[7];

    // tmo only rises when the limit, not the owner, ended the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 4'd0;
            tmo      <= 1'b0;
        end else begin
            if (grant_entry) begin
                hold_cnt <= 4'd0;
                tmo      <= 1'b0;
            end else begin
                if (state == GRANT) begin
                    hold_cnt <= hold_cnt + 4'd1;
                end
                if (timeout_exit) begin
                    tmo <= 1'b1;
                end
            end
        end
    end
`else
    logic [4:0] unused_sink;

    assign limit_hit   = 1'b0;
    assign tmo         = 1'b0;
    assign unused_sink = {io_in[7], 4'(TIMEOUT)};
`endif

    assign busy   = (state != IDLE);
    assign io_out = {tmo, busy, gnt_idx, gnt};

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Self-checking bench for rr_arbiter_ctrl: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a behavioural round-robin model.
module tb_rr_arbiter_ctrl;

    localparam int TIMEOUT = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       done;
    logic       spare;
    logic [3:0] req;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int errors   = 0;
    int checks   = 0;
    bit check_en = 1'b0;

    assign io_in = {spare, done, req, rst_n, clk};

    rr_arbiter_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // phase: 0 idle, 1 granted, 2 release gap; held counts granted cycles so far.
    typedef struct {
        int phase;
        int owner;
        int ptr;
        int held;
        bit tmo;
    } model_t;

    model_t mdl;

    function automatic model_t model_next(model_t m, logic [3:0] r, logic d);
        model_t n;
        bit     found;
        n     = m;
        found = 1'b0;
        case (m.phase)
            0: begin
                if (r != 4'b0000) begin
                    for (int k = 0; k < 4; k++) begin
                        if (!found && r[(m.ptr + k) % 4]) begin
                            found   = 1'b1;
                            n.owner = (m.ptr + k) % 4;
                        end
                    end
                    n.phase = 1;
                    n.held  = 1;
                    n.tmo   = 1'b0;
                end
            end
            1: begin
                if (d || !r[m.owner]) begin
                    n.phase = 2;
                    n.ptr   = (m.owner + 1) % 4;
                end else if (TMO_EN && m.held >= TIMEOUT) begin
                    n.phase = 2;
                    n.ptr   = (m.owner + 1) % 4;
                    n.tmo   = 1'b1;
                end else begin
                    n.held = m.held + 1;
                end
            end
            default: n.phase = 0;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] model_out(model_t m);
        logic [3:0] g;
        g = (m.phase == 1) ? 4'(4'b0001 << m.owner) : 4'b0000;
        return {m.tmo, (m.phase != 0), 2'(m.owner), g};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl <= '{phase: 0, owner: 0, ptr: 0, held: 0, tmo: 1'b0};
        end else begin
            mdl <= model_next(mdl, req, done);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] eg, input logic [1:0] ei,
                               input logic eb, input logic et);
        logic [7:0] e;
        e = {et, eb, ei, eg};
        checks++;
        if (io_out !== e) begin
            errors++;
            $display("[TB] FAIL %s: io_out=%b expected=%b (tmo busy idx gnt)", name, io_out, e);
        end
    endtask

    // Inputs change just after posedge, so the value seen at a negedge is what the next edge uses.
    task automatic compareLoop();
        logic [3:0] last_req;
        logic [3:0] prev_gnt;
        logic [7:0] exp;
        int         waits[4];
        int         w;
        int         worst;
        last_req = 4'b0000;
        prev_gnt = 4'b0000;
        foreach (waits[i]) waits[i] = 0;
        forever begin
            @(negedge clk);
            if (check_en) begin
                exp = model_out(mdl);
                checks++;
                if (io_out !== exp) begin
                    errors++;
                    $display("[TB] FAIL model_cmp t=%0t: io_out=%b expected=%b", $time, io_out, exp);
                end
                checks++;
                if (!$onehot0(io_out[3:0])) begin
                    errors++;
                    $display("[TB] FAIL gnt_onehot t=%0t: gnt=%b expected at most one bit", $time, io_out[3:0]);
                end
                if (prev_gnt == 4'b0000 && io_out[3:0] != 4'b0000) begin
                    w     = 0;
                    worst = 0;
                    for (int i = 0; i < 4; i++) if (io_out[i]) w = i;
                    for (int i = 0; i < 4; i++) begin
                        if (i == w) waits[i] = 0;
                        else if (last_req[i]) waits[i]++;
                        if (waits[i] > worst) worst = waits[i];
                    end
                    checks++;
                    if (worst > 3) begin
                        errors++;
                        $display("[TB] FAIL fairness t=%0t: waited %0d grants, limit 3", $time, worst);
                    end
                end
                for (int i = 0; i < 4; i++) if (!last_req[i]) waits[i] = 0;
            end
            last_req = req;
            prev_gnt = io_out[3:0];
        end
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] exp_g;
        logic [1:0] exp_i;
        logic       d;

        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        spare = 1'b0;
        fork
            compareLoop();
        join_none

        tick();
        tick();
        checkOutput("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        check_en = 1'b1;
        rst_n    = 1'b1;
        tick();
        checkOutput("idle_after_reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Full rotation with all four requesting.
        applyStimulus(4'b1111, 1'b0);
        tick();
        checkOutput("rr_first", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            exp_i = 2'(i % 4);
            exp_g = 4'b0001 << exp_i;
            applyStimulus(4'b1111, 1'b1);
            tick();
            checkOutput("rr_release", 4'b0000, 2'(i - 1), 1'b1, 1'b0);
            applyStimulus(4'b1111, 1'b0);
            tick();
            checkOutput("rr_idle_gap", 4'b0000, 2'(i - 1), 1'b0, 1'b0);
            tick();
            checkOutput("rr_next", exp_g, exp_i, 1'b1, 1'b0);
        end
        applyStimulus(4'b0000, 1'b0);
        tick();
        tick();

        // Requester 3 alone, then the pointer must wrap to 0.
        spare = 1'b1;
        applyStimulus(4'b1000, 1'b0);
        tick();
        checkOutput("only_req3", 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkOutput("req3_drop", 4'b0000, 2'd3, 1'b1, 1'b0);
        tick();
        checkOutput("req3_idle", 4'b0000, 2'd3, 1'b0, 1'b0);
        applyStimulus(4'b1001, 1'b0);
        tick();
        checkOutput("ptr_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);
        spare = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        tick();
        tick();

        // Asynchronous reset in the middle of a grant.
        applyStimulus(4'b1100, 1'b0);
        tick();
        checkOutput("pre_reset_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b0110, 1'b0);
        rst_n = 1'b1;
        tick();
        checkOutput("post_reset_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        tick();
        tick();

`ifdef ARB_TIMEOUT_EN
        applyStimulus(4'b0010, 1'b0);
        tick();
        checkOutput("tmo_cycle1", 4'b0010, 2'd1, 1'b1, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            checkOutput("tmo_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        tick();
        checkOutput("tmo_fire", 4'b0000, 2'd1, 1'b1, 1'b1);
        tick();
        checkOutput("tmo_idle", 4'b0000, 2'd1, 1'b0, 1'b1);
        tick();
        checkOutput("tmo_clear", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("limit_cycle4", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(4'b0010, 1'b1);
        tick();
        checkOutput("done_at_limit", 4'b0000, 2'd1, 1'b1, 1'b0);
`else
        applyStimulus(4'b0010, 1'b0);
        tick();
        checkOutput("hold_start", 4'b0010, 2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        checkOutput("hold_forever", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(4'b0010, 1'b1);
        tick();
        checkOutput("hold_done", 4'b0000, 2'd1, 1'b1, 1'b0);
`endif
        applyStimulus(4'b0000, 1'b0);
        tick();
        tick();

        // Long randomized run; requests are sticky-ish so some are held across grants.
        r = 4'b0000;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(5) == 0) r[b] = ~r[b];
            end
            d     = ($urandom_range(4) == 0);
            spare = 1'($urandom_range(1));
            applyStimulus(r, d);
            tick();
        end

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_ctrl.md
RR_ARBITER_CTRL -- requirements
Module: rr_arbiter_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 8, grant hold limit in clock cycles; legal range 2..15.
REQ-002 Ports SHALL be the standard 8-bit user-module pair io_in[7:0] / io_out[7:0], with bit fields below.
REQ-003 io_in[0]  input  1  clk; single clock, all state on rising edge.
REQ-004 io_in[1]  input  1  rst_n; reset is asynchronous and active-low.
REQ-005 io_in[5:2]  input  4  req[3:0]; level request per requester; req[0] = io_in[2].
REQ-006 io_in[6]  input  1  done; owner finished with the shared resource.
REQ-007 io_in[7]  input  1  unused; SHALL be ignored.
REQ-008 io_out[3:0]  output  4  gnt[3:0]; one-hot grant, registered.
REQ-009 io_out[5:4]  output  2  gnt_idx; index of current or last owner, registered.
REQ-010 io_out[6]  output  1  busy; high when state != IDLE.
REQ-011 io_out[7]  output  1  tmo; sticky timeout flag.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, GRANT, RELEASE.
REQ-013 IDLE: with any req high at an edge, go to GRANT; gnt asserted from that edge (1-cycle request-to-grant latency).
REQ-014 Winner SHALL be the first set req scanning ptr, ptr+1, ... mod 4; ptr is the 2-bit round-robin pointer.
REQ-015 IDLE with req == 0: stay IDLE, gnt = 0.
REQ-016 GRANT: hold gnt while req[gnt_idx] = 1 and done = 0.
REQ-017 GRANT exit: done = 1 or req[gnt_idx] = 0 at an edge -> RELEASE; gnt = 0 from that edge; ptr <= gnt_idx + 1 mod 4 (wraps 3 -> 0).
REQ-018 RELEASE: exactly one cycle with gnt = 0, then IDLE unconditionally.
REQ-019 Back-to-back handoff SHALL take 3 edges from the exit edge to the next grant: RELEASE, IDLE, then GRANT.
REQ-020 Requests arriving or dropping in RELEASE SHALL be ignored until IDLE.
REQ-021 gnt SHALL never have more than one bit set; gnt = 0 whenever state != GRANT.
REQ-022 gnt_idx SHALL update only on entry to GRANT and hold its value through RELEASE and IDLE.
REQ-023 tmo SHALL be cleared on every entry to GRANT.
REQ-024 busy SHALL be combinational from the state register only.

Reset
REQ-025 rst_n low SHALL immediately force state = IDLE, gnt = 0, gnt_idx = 0, ptr = 0, hold counter = 0, tmo = 0, busy = 0.
REQ-026 Reset asserted mid-GRANT SHALL drop gnt without passing through RELEASE.
REQ-027 After rst_n deasserts, the first arbitration SHALL start with ptr = 0.

Configuration
REQ-028 Macro ARB_TIMEOUT_EN compiled in: a 4-bit hold counter clears on GRANT entry and increments each cycle in GRANT.
REQ-029 With ARB_TIMEOUT_EN, when the counter equals TIMEOUT-1 and done = 0 and req[gnt_idx] = 1, the next edge SHALL go to RELEASE, set tmo, and advance ptr as in REQ-017.
REQ-030 With ARB_TIMEOUT_EN, if done = 1 or req drops in the same cycle as the limit, normal exit SHALL occur and tmo SHALL stay 0.
REQ-031 Without ARB_TIMEOUT_EN: no counter; grant is held indefinitely until done or req drop; tmo is tied to 0.

Verification
REQ-032 Reset, then req = 4'b1111 -> gnt = 0001 one edge later; done pulse -> gnt sequence 0010, 0100, 1000, 0001 with 2 idle-gap cycles between grants.
REQ-033 req = 4'b1000 only -> gnt = 1000, gnt_idx = 3; drop req[3] -> RELEASE, ptr wraps to 0; then req = 4'b0001 -> gnt = 0001.
REQ-034 ARB_TIMEOUT_EN, TIMEOUT = 4, req[1] held, done = 0 -> gnt = 0010 for exactly 4 cycles, then gnt = 0 and tmo = 1; next grant clears tmo.
REQ-035 ARB_TIMEOUT_EN, TIMEOUT = 4, done = 1 on cycle 4 of the grant -> normal release, tmo = 0.
REQ-036 rst_n pulsed low mid-GRANT between clock edges -> gnt = 0, busy = 0 without waiting for a clock edge; after release, req = 4'b0110 -> gnt = 0010.
REQ-037 Random req/done for 10k cycles -> gnt always one-hot or zero, and no requester with req held high waits more than 3 grants.
